key_press_decoder: RTL and testbench

// - Front-end for the clock's 5 push-buttons. Sits upstream of mode_sel, mode_clock, mode_date, mode_watch, mode_alarm and alarm.
// - Synchronises and debounces the raw key pins.
// - Emits single-cycle press, long-press, auto-repeat and release strobes per key, so setting digits can be scrolled by holding a key.

---
 rtl/key_pkg.sv | 29 ++
 rtl/key_press_decoder_channel.sv | 120 ++++++++++++
 rtl/key_press_decoder.sv | 75 +++++++
 tb/tb_key_press_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button front-end: channel state encoding,
// key index constants used by mode_sel, and a small sizing helper.
package key_pkg;

  localparam logic [2:0] KS_IDLE     = 3'd0;
  localparam logic [2:0] KS_PRESS_DB = 3'd1;
  localparam logic [2:0] KS_HELD     = 3'd2;
  localparam logic [2:0] KS_LONG     = 3'd3;
  localparam logic [2:0] KS_REL_DB   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = KS_IDLE,
    ST_PRESS_DB = KS_PRESS_DB,
    ST_HELD     = KS_HELD,
    ST_LONG     = KS_LONG,
    ST_REL_DB   = KS_REL_DB
  } key_state_e;

  localparam int KEY_MODE  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_SET   = 3;
  localparam int KEY_ALARM = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_press_decoder_channel.sv
// Per-key debounce / long-press / auto-repeat state machine driven by the
// shared ms tick. Strobes are registered and exclusive within a cycle.
module key_channel_fsm
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pr,
  output logic key_out,
  output logic key_long,
  output logic key_rpt,
  output logic key_rel,
  output logic key_level
);

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(max_int(LONG_MS, REPEAT_MS) + 1);
  localparam logic [DB_W-1:0]   DB_END   = DB_W'(DEBOUNCE_MS);
  localparam logic [HOLD_W-1:0] LONG_END = HOLD_W'(LONG_MS);
  localparam logic [HOLD_W-1:0] RPT_END  = HOLD_W'(REPEAT_MS);

  key_state_e        state, state_n;
  logic [DB_W-1:0]   db_cnt, db_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n, hold_inc;
  logic              was_long, was_long_n;
  logic              out_n, long_n, rpt_n, rel_n;

  always_comb begin
    state_n    = state;
    db_n       = db_cnt;
    hold_n     = hold_cnt;
    was_long_n = was_long;
    out_n      = 1'b0;
    long_n     = 1'b0;
    rpt_n      = 1'b0;
    rel_n      = 1'b0;
    hold_inc   = hold_cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        if (pr) begin
          state_n = ST_PRESS_DB;
          db_n    = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!pr) begin
          state_n = ST_IDLE;
        end else if (db_cnt == DB_END) begin
          state_n = ST_HELD;
          out_n   = 1'b1;
          hold_n  = '0;
        end else if (tick) begin
          db_n = db_cnt + 1'b1;
        end
      end
      ST_HELD, ST_LONG: begin
        if (tick) begin
          if (state == ST_HELD && hold_inc == LONG_END) begin
            state_n = ST_LONG;
            long_n  = 1'b1;
            hold_n  = '0;
          end else if (state == ST_LONG && hold_inc == RPT_END) begin
            rpt_n  = 1'b1;
            hold_n = '0;
          end else begin
            hold_n = hold_inc;
          end
        end
        // A strobe due on the same edge as the first released sample still fires.
        if (!pr) begin
          was_long_n = (state_n == ST_LONG);
          state_n    = ST_REL_DB;
          db_n       = '0;
        end
      end
      ST_REL_DB: begin
        if (pr) begin
          state_n = was_long ? ST_LONG : ST_HELD;
        end else if (db_cnt == DB_END) begin
          state_n = ST_IDLE;
          rel_n   = 1'b1;
          hold_n  = '0;
        end else if (tick) begin
          db_n = db_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      was_long <= 1'b0;
      key_out  <= 1'b0;
      key_long <= 1'b0;
      key_rpt  <= 1'b0;
      key_rel  <= 1'b0;
    end else begin
      state    <= state_n;
      db_cnt   <= db_n;
      hold_cnt <= hold_n;
      was_long <= was_long_n;
      key_out  <= out_n;
      key_long <= long_n;
      key_rpt  <= rpt_n;
      key_rel  <= rel_n;
    end
  end

  assign key_level = (state == ST_HELD) || (state == ST_LONG) || (state == ST_REL_DB);

endmodule

// File: rtl/key_press_decoder.sv
// Push-button front-end: 2-flop synchronisers, a shared 1 ms tick prescaler
// and one independent channel FSM per key.
module key_press_decoder
  import key_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int NUM_KEYS       = 5,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_rpt,
  output logic [NUM_KEYS-1:0] key_rel,
  output logic [NUM_KEYS-1:0] key_level
);

  localparam int DIV = CLK_FREQ / 1000;
  localparam logic [NUM_KEYS-1:0] RELEASED = {NUM_KEYS{KEY_ACTIVE_LOW}};

  logic [NUM_KEYS-1:0] sync1, sync2, pr;
  logic                tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign pr = sync2 ^ RELEASED;

  generate
    if (DIV <= 1) begin : g_tick_const
      assign tick = 1'b1;
    end else begin : g_tick_cnt
      localparam int PW = $clog2(DIV);
      localparam logic [PW-1:0] PRE_END = PW'(DIV - 1);
      logic [PW-1:0] pre;
      always_ff @(posedge clk) begin
        if (rst)                pre <= '0;
        else if (pre == PRE_END) pre <= '0;
        else                     pre <= pre + 1'b1;
      end
      assign tick = (pre == PRE_END);
    end
  endgenerate

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel_fsm #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .pr       (pr[i]),
      .key_out  (key_out[i]),
      .key_long (key_long[i]),
      .key_rpt  (key_rpt[i]),
      .key_rel  (key_rel[i]),
      .key_level(key_level[i])
    );
  end

endmodule

// File: tb/tb_key_press_decoder.sv
// Bench for key_press_decoder: run-length/hold-time reference model compared
// every cycle, directed scenarios pinned by literals, then randomized traffic.
module tb_key_press_decoder;
  import key_pkg::*;

  localparam int N = 5;
  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] key_out, key_long, key_rpt, key_rel, key_level;

  always #5 clk = ~clk;

  key_press_decoder #(
    .CLK_FREQ(1000), .NUM_KEYS(N), .DEBOUNCE_MS(D), .LONG_MS(L),
    .REPEAT_MS(R), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_out(key_out),
    .key_long(key_long), .key_rpt(key_rpt), .key_rel(key_rel),
    .key_level(key_level)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [N-1:0] pressed = '0;

  // Model: pr pipeline, run length of the sampled pr, and accumulated hold time.
  logic [N-1:0] m_s1, m_s2, m_prev, m_level;
  int           m_run[N];
  int           m_hold[N];
  logic [N-1:0] e_out, e_long, e_rpt, e_rel;
  int q_out[N][$], q_long[N][$], q_rpt[N][$], q_rel[N][$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_edge();
    logic [N-1:0] seen;
    e_out = '0; e_long = '0; e_rpt = '0; e_rel = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_level = '0;
      for (int k = 0; k < N; k++) begin m_run[k] = 0; m_hold[k] = 0; end
    end else begin
      seen = m_s2;
      for (int k = 0; k < N; k++) begin
        if (seen[k] == m_prev[k]) m_run[k]++;
        else m_run[k] = 1;
        if (!m_level[k]) begin
          if (seen[k] && m_run[k] == D + 2) begin
            e_out[k] = 1'b1; m_level[k] = 1'b1; m_hold[k] = 0;
          end
        end else begin
          if (m_prev[k]) begin
            m_hold[k]++;
            if (m_hold[k] == L) e_long[k] = 1'b1;
            else if (m_hold[k] > L && (m_hold[k] - L) % R == 0) e_rpt[k] = 1'b1;
          end
          if (!seen[k] && m_run[k] == D + 2) begin
            e_rel[k] = 1'b1; m_level[k] = 1'b0;
          end
        end
        m_prev[k] = seen[k];
        if (e_out[k])  q_out[k].push_back(t);
        if (e_long[k]) q_long[k].push_back(t);
        if (e_rpt[k])  q_rpt[k].push_back(t);
        if (e_rel[k])  q_rel[k].push_back(t);
      end
      m_s2 = m_s1;
      m_s1 = pressed;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("key_out",   int'(key_out),   int'(e_out));
    chk("key_long",  int'(key_long),  int'(e_long));
    chk("key_rpt",   int'(key_rpt),   int'(e_rpt));
    chk("key_rel",   int'(key_rel),   int'(e_rel));
    chk("key_level", int'(key_level), int'(m_level));
    t++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_keys(input logic [N-1:0] v);
    pressed = v;
    key_in  = ~v;
  endtask

  task automatic start_scenario();
    set_keys('0);
    run(12);
    for (int k = 0; k < N; k++) begin
      q_out[k].delete(); q_long[k].delete(); q_rpt[k].delete(); q_rel[k].delete();
    end
    t = 0;
  endtask

  initial begin
    set_keys('0);
    rst = 1'b1;
    run(3);
    chk("reset_out",   int'(key_out),   0);
    chk("reset_level", int'(key_level), 0);
    rst = 1'b0;

    // Clean press of KEY_DOWN held 8 cycles
    start_scenario();
    set_keys(5'b00100); run(8);
    chk("s1_level_model", int'(m_level[KEY_DOWN]), 1);
    set_keys('0); run(12);
    chk("s1_out_n",  q_out[KEY_DOWN].size(), 1);
    chk("s1_out_t",  qat(q_out[KEY_DOWN], 0), 7);
    chk("s1_rel_t",  qat(q_rel[KEY_DOWN], 0), 15);
    chk("s1_long_n", q_long[KEY_DOWN].size(), 0);

    // Bouncing KEY_MODE, final pressed edge at t=6
    start_scenario();
    for (int i = 0; i <= 6; i++) begin
      set_keys((i % 2 == 0) ? 5'b00001 : 5'b00000);
      step();
    end
    run(10);
    set_keys('0); run(12);
    chk("s2_out_n", q_out[KEY_MODE].size(), 1);
    chk("s2_out_t", qat(q_out[KEY_MODE], 0), 13);
    chk("s2_rel_n", q_rel[KEY_MODE].size(), 1);

    // Long hold of KEY_UP for 30 cycles
    start_scenario();
    set_keys(5'b00010); run(30);
    set_keys('0); run(12);
    chk("s3_out_t",  qat(q_out[KEY_UP], 0), 7);
    chk("s3_long_t", qat(q_long[KEY_UP], 0), 17);
    chk("s3_rpt_n",  q_rpt[KEY_UP].size(), 5);
    for (int i = 0; i < 5; i++) chk("s3_rpt_t", qat(q_rpt[KEY_UP], i), 20 + 3 * i);
    chk("s3_rel_t",  qat(q_rel[KEY_UP], 0), 37);

    // Release glitch on KEY_SET after long press
    start_scenario();
    set_keys(5'b01000); run(19);
    set_keys('0); run(2);
    set_keys(5'b01000); run(12);
    set_keys('0); run(12);
    chk("s4_long_t", qat(q_long[KEY_SET], 0), 17);
    chk("s4_rpt0_t", qat(q_rpt[KEY_SET], 0), 20);
    chk("s4_rpt1_t", qat(q_rpt[KEY_SET], 1), 25);
    chk("s4_rpt2_t", qat(q_rpt[KEY_SET], 2), 28);
    chk("s4_rpt3_t", qat(q_rpt[KEY_SET], 3), 31);
    chk("s4_rel_n",  q_rel[KEY_SET].size(), 1);
    chk("s4_rel_t",  qat(q_rel[KEY_SET], 0), 40);

    // All keys pressed together
    start_scenario();
    set_keys('1); run(10);
    for (int k = 0; k < N; k++) chk("s5_out_t", qat(q_out[k], 0), 7);
    set_keys('0); run(12);

    // Reset while KEY_ALARM is in LONG
    start_scenario();
    set_keys(5'b10000); run(20);
    rst = 1'b1; run(2);
    chk("s6_rst_out",   int'(key_out),   0);
    chk("s6_rst_level", int'(key_level), 0);
    rst = 1'b0; run(12);
    chk("s6_long_t", qat(q_long[KEY_ALARM], 0), 17);
    chk("s6_out_n",  q_out[KEY_ALARM].size(), 2);
    chk("s6_out2_t", qat(q_out[KEY_ALARM], 1), 29);
    chk("s6_rel_n",  q_rel[KEY_ALARM].size(), 0);
    set_keys('0); run(12);

    // Randomized traffic with varying bounce density and occasional reset
    for (int blk = 0; blk < 20; blk++) begin
      int flip_mod;
      case ($urandom_range(0, 2))
        0: flip_mod = 3;
        1: flip_mod = 12;
        default: flip_mod = 40;
      endcase
      for (int c = 0; c < 200; c++) begin
        logic [N-1:0] v;
        v = pressed;
        for (int k = 0; k < N; k++)
          if ($urandom_range(0, flip_mod - 1) == 0) v[k] = ~v[k];
        set_keys(v);
        rst = ($urandom_range(0, 999) < 2);
        step();
      end
    end
    rst = 1'b0;
    set_keys('0);
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
